prog_instr_memory: RTL and testbench
====================================

Name: prog_instr_memory

Overview:
Loadable instruction store that replaces the hard-coded instruction table. A boot/debug source streams a program in through a valid/ready load port. The block then serves single-cycle registered fetches indexed by PC to the fetch stage. Fetches beyond the loaded program length return a NOP and raise a fault flag. Width, depth and NOP encoding are parametrised.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 8, PC / address width in bits
DEPTH, 256, number of memory words; must be ≤ 2**ADDR_W and ≥ 2
NOP_CODE, 8'h00, word returned on out-of-range fetch and at reset (DATA_W bits)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ld_valid  in  1  load word present
ld_data  in  DATA_W  load word
ld_last  in  1  marks final word of program, qualified by ld_valid
ld_ready  out  1  block accepts load word this cycle
reload  in  1  single-cycle request to re-enter load mode
fetch_en  in  1  fetch request this cycle
PC  in  ADDR_W  fetch address
Instruction_Code  out  DATA_W  fetched word, registered
instr_valid  out  1  Instruction_Code updated by a fetch issued the previous cycle
addr_fault  out  1  fetch of previous cycle was out of range
loading  out  1  high while in LOAD state
prog_len  out  ADDR_W+1  number of words in the loaded program

Behaviour:
- States: LOAD, RUN. Memory array has no reset; contents persist across reset and reload.
- reset low (async): state=LOAD, ld_ptr=0, prog_len=0, Instruction_Code=NOP_CODE, instr_valid=0, addr_fault=0. ld_ready = (state==LOAD) & reset, so it reads 0 while reset is held. loading = (state==LOAD).
- LOAD:
  - A transfer occurs when ld_valid & ld_ready at a rising edge: Mem[ld_ptr]<=ld_data, ld_ptr<=ld_ptr+1.
  - If the transfer carries ld_last, or ld_ptr==DEPTH-1: prog_len<=ld_ptr+1, state<=RUN, ld_ptr<=0.
  - ld_last without ld_valid is ignored. ld_valid low holds all state, so gaps are allowed.
  - In LOAD, fetch_en is ignored: instr_valid=0, addr_fault=0, Instruction_Code holds its value.
  - reload is ignored in LOAD.
- RUN:
  - ld_ready=0; ld_valid is ignored.
  - fetch_en=1 and PC<prog_len: next edge Instruction_Code<=Mem[PC], instr_valid<=1, addr_fault<=0. Latency is 1 cycle; back-to-back fetches give one result per cycle.
  - fetch_en=1 and PC≥prog_len: Instruction_Code<=NOP_CODE, instr_valid<=1, addr_fault<=1.
  - fetch_en=0: Instruction_Code holds, instr_valid<=0, addr_fault<=0.
  - reload=1: state<=LOAD, ld_ptr<=0, prog_len<=0, instr_valid<=0, addr_fault<=0. reload takes priority over a simultaneous fetch_en, and that fetch produces no result.
- Boundaries:
  - Minimum program length is 1 word. prog_len range is 1..DEPTH in RUN and 0 in LOAD.
  - The PC comparison is unsigned at ADDR_W+1 bits, so PC values ≥ DEPTH always fault.
  - An async reset asserted mid-load returns to LOAD with ld_ptr=0. The partial program is overwritten by the next load.

Test Plan:
1. Reset, then load 0x25,0x61,0x2C,0xC1,0x6B,0x1D with ld_last on the 6th word -> ld_ready=1 during load; loading falls and prog_len=6 the cycle after the 6th transfer.
2. In RUN, fetch_en=1 with PC=0,1,2,3,4,5 on consecutive cycles -> Instruction_Code=0x25,0x61,0x2C,0xC1,0x6B,0x1D one cycle later each; instr_valid=1 continuously; addr_fault=0.
3. Fetch PC=6, then PC=255 -> Instruction_Code=0x00, instr_valid=1, addr_fault=1 each cycle. Drop fetch_en -> instr_valid=0, addr_fault=0, Instruction_Code stays 0x00.
4. DEPTH=8: stream 8 words 0x10..0x17 with ld_valid toggling every other cycle and no ld_last -> exactly 8 writes; RUN entered automatically with prog_len=8; fetch PC=7 returns 0x17.
5. During load, pull reset low after 3 words, release, then load 2 words 0xAA,0xBB with ld_last -> prog_len=2; fetch PC=1 returns 0xBB; fetch PC=2 faults.
6. In RUN, assert reload together with fetch_en at PC=0 -> instr_valid=0 next cycle, loading=1, prog_len=0; reload a 1-word program 0x3C with ld_last -> prog_len=1; fetch PC=0 returns 0x3C.

Source files
------------

// File: rtl/prog_instr_memory.sv
// prog_instr_memory: loadable instruction store with a valid/ready load port and registered PC-indexed fetch
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   ld_valid/ld_data    program word offered by the boot/debug source
//   ld_last             final word of the program (qualified by ld_valid)
//   ld_ready            word accepted this cycle (LOAD state, out of reset)
//   reload              one-cycle request to return from RUN to LOAD
//   fetch_en, PC        fetch request and address
//   Instruction_Code    fetched word, one cycle after the request
//   instr_valid         Instruction_Code was updated by last cycle's fetch
//   addr_fault          last cycle's fetch was beyond the loaded program
//   loading             high in LOAD state
//   prog_len            words in the loaded program (0 while loading)
module prog_instr_memory #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH = 256,
    parameter logic [DATA_W-1:0] NOP_CODE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] Instruction_Code,
    output logic              instr_valid,
    output logic              addr_fault,
    output logic              loading,
    output logic [ADDR_W:0]   prog_len
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic {LOAD, RUN} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0] ld_ptr;
    logic xfer, done, hit;
    assign loading = state == LOAD;
    assign ld_ready = loading & reset;
    assign xfer = ld_valid & ld_ready;
    // a full memory ends the load even without ld_last
    assign done = xfer & (ld_last | ld_ptr == PW'(DEPTH - 1));
    // prog_len never exceeds DEPTH, so a hit always indexes a real word
    assign hit = {1'b0, PC} < prog_len;
    always_comb begin
        state_nx = state;
        if (state == LOAD) state_nx = done ? RUN : LOAD;
        else state_nx = reload ? LOAD : RUN;
    end
    always_ff @(posedge clk)
        if (xfer) mem[ld_ptr] <= ld_data;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= LOAD;
            ld_ptr <= '0;
            prog_len <= '0;
            Instruction_Code <= NOP_CODE;
            instr_valid <= 1'b0;
            addr_fault <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == LOAD) begin
                instr_valid <= 1'b0;
                addr_fault <= 1'b0;
                if (xfer) ld_ptr <= done ? '0 : ld_ptr + PW'(1);
                if (done) prog_len <= (ADDR_W + 1)'(ld_ptr) + (ADDR_W + 1)'(1);
            end else if (reload) begin
                ld_ptr <= '0;
                prog_len <= '0;
                instr_valid <= 1'b0;
                addr_fault <= 1'b0;
            end else begin
                instr_valid <= fetch_en;
                addr_fault <= fetch_en & ~hit;
                if (fetch_en) Instruction_Code <= hit ? mem[PC[PW-1:0]] : NOP_CODE;
            end
        end
endmodule

// File: tb/tb_prog_instr_memory.sv
// tb_prog_instr_memory: directed, table-driven and randomized checks of prog_instr_memory
module tb_prog_instr_memory;
    logic clk = 0, reset = 0, ld_valid = 0, ld_last = 0, reload = 0, fetch_en = 0;
    logic [7:0] ld_data = 0, PC = 0;
    logic [7:0] code0, code8;
    logic rdy0, rdy8, iv0, iv8, af0, af8, ld0, ld8;
    logic [8:0] pl0, pl8;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    prog_instr_memory u0 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(rdy0), .reload(reload), .fetch_en(fetch_en), .PC(PC),
        .Instruction_Code(code0), .instr_valid(iv0), .addr_fault(af0), .loading(ld0), .prog_len(pl0)
    );
    prog_instr_memory #(.DEPTH(8)) u8 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(rdy8), .reload(reload), .fetch_en(fetch_en), .PC(PC),
        .Instruction_Code(code8), .instr_valid(iv8), .addr_fault(af8), .loading(ld8), .prog_len(pl8)
    );
    typedef struct {
        logic fe;
        logic [7:0] pc;
        logic [7:0] code;
        logic v;
        logic f;
    } vec_t;
    vec_t vec [9];
    logic [7:0] mem_m [256];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic load_word(input logic [7:0] d, input logic last);
        ld_valid = 1;
        ld_data = d;
        ld_last = last;
        step();
        ld_valid = 0;
        ld_last = 0;
    endtask
    task automatic do_reset();
        reset = 0;
        step();
        reset = 1;
        #1;
    endtask
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] prog1 [6];
        logic [7:0] code_m;
        int len, k, guard;
        logic fe;
        logic [7:0] pc;
        prog1 = '{8'h25, 8'h61, 8'h2C, 8'hC1, 8'h6B, 8'h1D};
        for (int i = 0; i < 6; i++) vec[i] = '{1, 8'(i), prog1[i], 1, 0};
        vec[6] = '{1, 8'd6, 8'h00, 1, 1};
        vec[7] = '{1, 8'd255, 8'h00, 1, 1};
        vec[8] = '{0, 8'd0, 8'h00, 0, 0};
        // reset state while held
        step();
        step();
        chk("rst_ld_ready", rdy0, 0);
        chk("rst_loading", ld0, 1);
        chk("rst_prog_len", pl0, 0);
        chk("rst_code", code0, 8'h00);
        chk("rst_valid", iv0, 0);
        chk("rst_fault", af0, 0);
        reset = 1;
        #1;
        chk("ld_ready_after_rst", rdy0, 1);
        // 6-word program
        for (int i = 0; i < 6; i++) begin
            chk("t1_ld_ready", rdy0, 1);
            chk("t1_loading", ld0, 1);
            load_word(prog1[i], i == 5);
            if (i == 4) chk("t1_len_midload", pl0, 0);
        end
        chk("t1_loading_fall", ld0, 0);
        chk("t1_prog_len", pl0, 6);
        chk("t1_ld_ready_run", rdy0, 0);
        // table-driven fetches, fetch_en held across consecutive entries
        for (int i = 0; i < 9; i++) begin
            fetch_en = vec[i].fe;
            PC = vec[i].pc;
            step();
            chk($sformatf("t23_code[%0d]", i), code0, vec[i].code);
            chk($sformatf("t23_valid[%0d]", i), iv0, vec[i].v);
            chk($sformatf("t23_fault[%0d]", i), af0, vec[i].f);
        end
        // DEPTH=8 auto-terminating load with gaps
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ld_valid = (i % 2) == 0;
            ld_data = 8'h10 + 8'(i / 2);
            step();
        end
        ld_valid = 1;
        ld_data = 8'hEE;
        chk("t4_ld_ready_full", rdy8, 0);
        step();
        ld_valid = 0;
        chk("t4_loading", ld8, 0);
        chk("t4_prog_len", pl8, 8);
        fetch_en = 1;
        PC = 7;
        step();
        chk("t4_code_pc7", code8, 8'h17);
        chk("t4_fault_pc7", af8, 0);
        PC = 0;
        step();
        chk("t4_code_pc0", code8, 8'h10);
        PC = 8;
        step();
        fetch_en = 0;
        chk("t4_fault_pc8", af8, 1);
        chk("t4_code_pc8", code8, 8'h00);
        // reset mid-load then fresh 2-word program
        do_reset();
        load_word(8'h01, 0);
        load_word(8'h02, 0);
        load_word(8'h03, 0);
        do_reset();
        chk("t5_loading", ld0, 1);
        chk("t5_prog_len0", pl0, 0);
        load_word(8'hAA, 0);
        load_word(8'hBB, 1);
        chk("t5_prog_len", pl0, 2);
        fetch_en = 1;
        PC = 1;
        step();
        chk("t5_code_pc1", code0, 8'hBB);
        chk("t5_fault_pc1", af0, 0);
        PC = 2;
        step();
        fetch_en = 0;
        chk("t5_fault_pc2", af0, 1);
        chk("t5_code_pc2", code0, 8'h00);
        // reload wins over simultaneous fetch; reload ignored while loading
        reload = 1;
        fetch_en = 1;
        PC = 0;
        step();
        reload = 0;
        fetch_en = 0;
        chk("t6_valid", iv0, 0);
        chk("t6_loading", ld0, 1);
        chk("t6_prog_len", pl0, 0);
        chk("t6_code_hold", code0, 8'h00);
        reload = 1;
        load_word(8'h3C, 1);
        reload = 0;
        chk("t6_prog_len1", pl0, 1);
        chk("t6_loading_fall", ld0, 0);
        fetch_en = 1;
        PC = 0;
        step();
        fetch_en = 0;
        chk("t6_code", code0, 8'h3C);
        chk("t6_valid_fetch", iv0, 1);
        chk("t6_fault", af0, 0);
        // randomized rounds against a behavioural model
        for (int i = 0; i < 6; i++) mem_m[i] = 8'h00;
        mem_m[0] = 8'h3C;
        code_m = 8'h3C;
        for (int r = 0; r < 4; r++) begin
            reload = 1;
            fetch_en = 1'($urandom);
            PC = 8'($urandom);
            step();
            reload = 0;
            fetch_en = 0;
            chk("rnd_reload_loading", ld0, 1);
            chk("rnd_reload_valid", iv0, 0);
            len = $urandom_range(1, 40);
            k = 0;
            guard = 0;
            while (k < len && guard < 200) begin
                ld_valid = 1'($urandom);
                ld_data = 8'($urandom);
                ld_last = ld_valid ? (k == len - 1) : 1'($urandom);
                step();
                if (ld_valid) begin
                    mem_m[k] = ld_data;
                    k++;
                end
                guard++;
            end
            ld_valid = 0;
            ld_last = 0;
            chk("rnd_load_done", k, len);
            chk("rnd_loading", ld0, 0);
            chk("rnd_prog_len", pl0, len);
            for (int c = 0; c < 100; c++) begin
                fe = ($urandom % 4) != 0;
                pc = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, len + 3));
                fetch_en = fe;
                PC = pc;
                step();
                if (fe) code_m = (int'(pc) < len) ? mem_m[pc] : 8'h00;
                chk("rnd_code", code0, code_m);
                chk("rnd_valid", iv0, fe);
                chk("rnd_fault", af0, fe && int'(pc) >= len);
            end
            fetch_en = 0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
